md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: cycles from MULT/MULTU acceptance to HI/LO update.
REQ-002 Parameter DIV_CYCLES, default 10: cycles from DIV/DIVU acceptance to HI/LO update.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  qualifies MDOp for one cycle; driven by EX stage decode.
REQ-006 MDOp  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-007 A  input  32  operand rs, forwarded value.
REQ-008 B  input  32  operand rt, forwarded value.
REQ-009 HiLoSel  input  1  1 selects HI, 0 selects LO on MDOut (MFHI/MFLO).
REQ-010 Busy  output  1  operation in flight; consumed by hazard unit to stall.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.
REQ-013 MDOut  output  32  HiLoSel ? HI : LO, combinational, feeds the EX result mux ahead of EX_MEM.

Function
REQ-014 Acceptance: Start=1, Busy=0, MDOp in {000..101} at a posedge = accepted at that edge (E0).
REQ-015 Start while Busy=1: ignored entirely; in-flight operation and HI/LO unaffected.
REQ-016 MULT/MULTU/DIV/DIVU accepted at E0: operands and op latched at E0; Busy=1 after E0.
REQ-017 Result latency: HI/LO written at edge E0+MULT_CYCLES (mult) or E0+DIV_CYCLES (div); Busy returns to 0 at that same edge.
REQ-018 During Busy, HI/LO hold pre-operation values; result held in internal registers only.
REQ-019 Down-counter loaded with latency-1 at E0, decremented each edge while Busy; commit on count 0.
REQ-020 States: IDLE (Busy=0) -> RUN on accepted mult/div; RUN -> IDLE on commit; MTHI/MTLO never leave IDLE.
REQ-021 MULT: signed 32x32 -> 64-bit product; HI=product[63:32], LO=product[31:0].
REQ-022 MULTU: unsigned 32x32 -> 64-bit product, same split.
REQ-023 DIV: signed, quotient truncated toward zero into LO, remainder (sign of dividend) into HI.
REQ-024 DIVU: unsigned quotient into LO, remainder into HI.
REQ-025 Divide by zero (B=0, DIV or DIVU): full DIV_CYCLES Busy period, HI/LO unchanged at commit.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no exception.
REQ-027 MTHI/MTLO accepted: HI (resp. LO) <= A at E0; Busy stays 0; one-cycle effect.
REQ-028 MDOp 110/111 with Start=1: no state change.
REQ-029 MDOut reflects HI/LO register values only, never in-flight results.
REQ-030 Start=1 in the same cycle Busy falls (commit edge): ignored, since Busy=1 when sampled; new op accepted next edge earliest.

Reset
REQ-031 Reset=1 asynchronously forces HI=0, LO=0, Busy=0, counter=0, state IDLE, internal result regs 0.
REQ-032 Reset mid-operation: operation abandoned, no HI/LO commit after release.
REQ-033 First acceptance possible at the first posedge with Reset=0.

Verification
REQ-034 MULT A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; HI/LO unchanged at cycles 1-9.
REQ-037 MTHI A=0x12345678, then HiLoSel=1 next cycle -> MDOut=0x12345678, Busy never asserted; DIVU B=0 after it -> HI still 0x12345678 after 10 cycles.
REQ-038 MULT accepted, Start with MTLO at cycle 2 -> MTLO ignored, LO = product at cycle 5.
REQ-039 DIV accepted, Reset pulse at cycle 4 (between edges) -> Busy=0, HI=LO=0 immediately and remain 0 through cycle 12.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at acceptance, held internally, and committed after a fixed latency.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiLoSel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        res_hi_q, res_hi_d;
    logic [31:0]        res_lo_q, res_lo_d;
    logic               res_wr_q, res_wr_d;

    logic               accept_s;
    logic [63:0]        prod_s;
    logic               div_signed_s;
    logic               a_neg_s, b_neg_s;
    logic [31:0]        a_mag_s, b_mag_s, b_nz_s;
    logic [31:0]        q_mag_s, r_mag_s;
    logic [31:0]        quo_s, rem_s;

    assign accept_s = Start && (state_q == S_IDLE) && (MDOp <= 3'b101);

    assign prod_s = MDOp[0] ? ({32'h0000_0000, A} * {32'h0000_0000, B})
                            : ({{32{A[31]}}, A} * {{32{B[31]}}, B});

    // Signed divide goes through magnitudes so 0x80000000 / -1 needs no special case.
    assign div_signed_s = ~MDOp[0];
    assign a_neg_s      = div_signed_s & A[31];
    assign b_neg_s      = div_signed_s & B[31];
    assign a_mag_s      = a_neg_s ? (~A + 32'd1) : A;
    assign b_mag_s      = b_neg_s ? (~B + 32'd1) : B;
    assign b_nz_s       = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    assign q_mag_s      = a_mag_s / b_nz_s;
    assign r_mag_s      = a_mag_s % b_nz_s;
    assign quo_s        = (a_neg_s ^ b_neg_s) ? (~q_mag_s + 32'd1) : q_mag_s;
    assign rem_s        = a_neg_s ? (~r_mag_s + 32'd1) : r_mag_s;

    // Next-state logic: acceptance in IDLE, countdown and commit in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (MDOp)
                        3'b000, 3'b001: begin
                            state_d  = S_RUN;
                            cnt_d    = CNT_W'(MULT_CYCLES - 1);
                            res_hi_d = prod_s[63:32];
                            res_lo_d = prod_s[31:0];
                            res_wr_d = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            state_d  = S_RUN;
                            cnt_d    = CNT_W'(DIV_CYCLES - 1);
                            res_hi_d = rem_s;
                            res_lo_d = quo_s;
                            res_wr_d = (B != 32'd0);
                        end
                        3'b100: hi_d = A;
                        3'b101: lo_d = A;
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_IDLE;
                    if (res_wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end else begin
                        hi_d = hi_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, architectural and staged result registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
        end
    end

    assign Busy  = (state_q == S_RUN);
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDOut = HiLoSel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; inputs change on negedge, outputs sampled on negedge.
module tb_md_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiLoSel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    int          chk_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .HiLoSel(HiLoSel), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one mult/div and checks Busy and HI/LO hold every cycle until the commit edge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] eh, input logic [31:0] el);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0;
        check_eq({tag, "_busy_e0"}, {31'd0, Busy}, 32'd1);
        for (int k = 1; k < lat; k++) begin
            @(negedge Clk);
            check_eq({tag, "_busy_mid"}, {31'd0, Busy}, 32'd1);
            check_eq({tag, "_hi_hold"}, HI, m_hi);
            check_eq({tag, "_lo_hold"}, LO, m_lo);
        end
        @(negedge Clk);
        m_hi = eh; m_lo = el;
        check_eq({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
        check_eq({tag, "_hi"}, HI, m_hi);
        check_eq({tag, "_lo"}, LO, m_lo);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; MDOp = 3'b000; A = 32'd0; B = 32'd0; HiLoSel = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge Clk);
        @(negedge Clk);
        check_eq("rst_busy", {31'd0, Busy}, 32'd0);
        check_eq("rst_hi", HI, 32'd0);
        check_eq("rst_lo", LO, 32'd0);
        Reset = 1'b0;

        run_op("mult_neg", 3'b000, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("divu", 3'b011, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        Start = 1'b1; MDOp = 3'b100; A = 32'h1234_5678;
        @(negedge Clk);
        Start = 1'b0; HiLoSel = 1'b1; m_hi = 32'h1234_5678;
        check_eq("mthi_busy", {31'd0, Busy}, 32'd0);
        #1;
        check_eq("mthi_mdout_hi", MDOut, m_hi);
        HiLoSel = 1'b0;
        #1;
        check_eq("mdout_lo", MDOut, m_lo);
        @(negedge Clk);

        run_op("divu_zero", 3'b011, 32'd55, 32'd0, 10, m_hi, m_lo);
        run_op("div_zero", 3'b010, 32'hFFFF_FF00, 32'd0, 10, m_hi, m_lo);

        Start = 1'b1; MDOp = 3'b110; A = 32'hCAFE_0000; B = 32'd1;
        @(negedge Clk);
        MDOp = 3'b111;
        @(negedge Clk);
        Start = 1'b0;
        check_eq("nop_busy", {31'd0, Busy}, 32'd0);
        check_eq("nop_hi", HI, m_hi);
        check_eq("nop_lo", LO, m_lo);

        // MTLO presented while a multiply is in flight must be dropped.
        Start = 1'b1; MDOp = 3'b000; A = 32'd7; B = 32'd6;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Start = 1'b1; MDOp = 3'b101; A = 32'hDEAD_BEEF;
        @(negedge Clk);
        Start = 1'b0;
        check_eq("mtlo_ign_busy", {31'd0, Busy}, 32'd1);
        check_eq("mtlo_ign_lo", LO, m_lo);
        @(negedge Clk);
        @(negedge Clk);
        check_eq("mtlo_ign_busy4", {31'd0, Busy}, 32'd1);
        @(negedge Clk);
        m_hi = 32'd0; m_lo = 32'd42;
        check_eq("mtlo_ign_done", {31'd0, Busy}, 32'd0);
        check_eq("mtlo_ign_hi", HI, m_hi);
        check_eq("mtlo_ign_lo2", LO, m_lo);

        // Start on the commit edge is ignored; the held request is taken one edge later.
        Start = 1'b1; MDOp = 3'b001; A = 32'd3; B = 32'd5;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        Start = 1'b1; MDOp = 3'b100; A = 32'h5555_AAAA;
        @(negedge Clk);
        m_hi = 32'd0; m_lo = 32'd15;
        check_eq("commit_edge_busy", {31'd0, Busy}, 32'd0);
        check_eq("commit_edge_hi", HI, m_hi);
        check_eq("commit_edge_lo", LO, m_lo);
        @(negedge Clk);
        Start = 1'b0; m_hi = 32'h5555_AAAA;
        check_eq("next_edge_mthi", HI, m_hi);

        // Reset pulse between edges during a divide.
        Start = 1'b1; MDOp = 3'b010; A = 32'd100; B = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        check_eq("pre_rst_hi", HI, m_hi);
        Reset = 1'b1;
        #1;
        check_eq("async_rst_busy", {31'd0, Busy}, 32'd0);
        check_eq("async_rst_hi", HI, 32'd0);
        check_eq("async_rst_lo", LO, 32'd0);
        #1;
        Reset = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge Clk);
            check_eq("post_rst_busy", {31'd0, Busy}, 32'd0);
            check_eq("post_rst_hi", HI, 32'd0);
            check_eq("post_rst_lo", LO, 32'd0);
        end
        Start = 1'b1; MDOp = 3'b101; A = 32'h0BAD_F00D;
        @(negedge Clk);
        Start = 1'b0;
        check_eq("post_rst_mtlo", LO, 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
